// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship spawner and its LFSR: lane indices,
// spawner state encodings and the Galois feedback mask.
package nexys_starship_pkg;

    localparam int LANE_TOP    = 0;
    localparam int LANE_BOTTOM = 1;
    localparam int LANE_LEFT   = 2;
    localparam int LANE_RIGHT  = 3;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One-hot so the state bits map straight onto q_SP_* and stray codes are detectable
    typedef enum logic [3:0] {
        SP_IDLE = 4'b0001,
        SP_GAP  = 4'b0010,
        SP_PICK = 4'b0100,
        SP_HOLD = 4'b1000
    } sp_state_t;

endpackage

// File: rtl/nexys_starship_lfsr.sv
// 16-bit Galois LFSR, shifting every clock; a zero value reloads the seed so it can never lock up.
module nexys_starship_lfsr
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] next;

    always_comb begin
        next = {1'b0, value[15:1]};
        if (value[0]) next = next ^ LFSR_MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 value <= SEED;
        else if (value == '0)    value <= SEED;
        else                     value <= next;
    end

endmodule

// File: rtl/nexys_starship_spawner.sv
// Decides when and in which lane a monster spawns: random gap, random free lane,
// request held until the lane reports busy or the hold times out.
module nexys_starship_spawner
    import nexys_starship_pkg::*;
#(
    parameter int          NUM_LANES   = 4,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          BASE_GAP    = 8,
    parameter int          MIN_GAP     = 2,
    parameter int          LEVEL_TICKS = 32,
    parameter int          MAX_LEVEL   = 6,
    parameter int          HOLD_MAX    = 4
) (
    input  logic                 timer_clk,
    input  logic                 Reset,
    input  logic                 play_flag,
    input  logic                 gameover_ctrl,
    input  logic [NUM_LANES-1:0] monster_busy,
    output logic [NUM_LANES-1:0] spawn_req,
    output logic [2:0]           level,
    output logic                 q_SP_Idle,
    output logic                 q_SP_Gap,
    output logic                 q_SP_Pick,
    output logic                 q_SP_Hold
);

    localparam int LVL_W  = $clog2(LEVEL_TICKS);
    localparam int HOLD_W = $clog2(HOLD_MAX);
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVEL_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
    localparam logic [2:0]        LEVEL_TOP = 3'(MAX_LEVEL);

    sp_state_t            state, state_n;
    logic [15:0]          lfsr;
    logic [NUM_LANES-1:0] busy_m, busy_s;
    logic [4:0]           gap_cnt, gap_cnt_n, gap_base, gap;
    logic [LVL_W-1:0]     lvl_cnt, lvl_cnt_n;
    logic [2:0]           level_n;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
    logic [1:0]           lane, lane_n, pick;
    logic                 found;
    logic [NUM_LANES-1:0] spawn_req_n;
    logic                 unused_lfsr;

    assign unused_lfsr = ^{lfsr[15:6], lfsr[3]};

    nexys_starship_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (timer_clk),
        .rst   (Reset),
        .value (lfsr)
    );

    // gap = max(BASE_GAP - level, MIN_GAP) + lfsr[2:0], kept in 5 bits
    always_comb begin
        if ({2'b00, level} + 5'(MIN_GAP) > 5'(BASE_GAP)) gap_base = 5'(MIN_GAP);
        else                                            gap_base = 5'(BASE_GAP) - {2'b00, level};
        gap = gap_base + {2'b00, lfsr[2:0]};
    end

    // First free lane at or above the random candidate, wrapping; lowest offset wins
    always_comb begin
        found = 1'b0;
        pick  = lfsr[5:4];
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (!busy_s[(int'(lfsr[5:4]) + i) % NUM_LANES]) begin
                found = 1'b1;
                pick  = 2'((int'(lfsr[5:4]) + i) % NUM_LANES);
            end
        end
    end

    always_comb begin
        state_n     = state;
        gap_cnt_n   = gap_cnt;
        lvl_cnt_n   = lvl_cnt;
        level_n     = level;
        hold_cnt_n  = hold_cnt;
        lane_n      = lane;
        spawn_req_n = spawn_req;
        case (state)
            SP_IDLE: begin
                spawn_req_n = '0;
                level_n     = '0;
                lvl_cnt_n   = '0;
                if (play_flag) begin
                    gap_cnt_n = gap;
                    state_n   = SP_GAP;
                end
            end
            SP_GAP: begin
                gap_cnt_n = gap_cnt - 5'd1;
                if (gap_cnt == 5'd1) state_n = SP_PICK;
            end
            SP_PICK: begin
                if (found) begin
                    spawn_req_n       = '0;
                    spawn_req_n[pick] = 1'b1;
                    hold_cnt_n        = '0;
                    lane_n            = pick;
                    state_n           = SP_HOLD;
                end
            end
            SP_HOLD: begin
                if (busy_s[lane] || hold_cnt == HOLD_LAST) begin
                    spawn_req_n = '0;
                    gap_cnt_n   = gap;
                    state_n     = SP_GAP;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                spawn_req_n = '0;
                level_n     = '0;
                lvl_cnt_n   = '0;
                state_n     = SP_IDLE;
            end
        endcase

        if (state inside {SP_GAP, SP_PICK, SP_HOLD}) begin
            if (lvl_cnt == LVL_LAST) begin
                lvl_cnt_n = '0;
                if (level != LEVEL_TOP) level_n = level + 3'd1;
            end else begin
                lvl_cnt_n = lvl_cnt + LVL_W'(1);
            end
        end

        // Game over overrides every other transition
        if (gameover_ctrl) begin
            state_n     = SP_IDLE;
            spawn_req_n = '0;
            level_n     = '0;
            lvl_cnt_n   = '0;
        end
    end

    always_ff @(posedge timer_clk or posedge Reset) begin
        if (Reset) begin
            state     <= SP_IDLE;
            busy_m    <= '0;
            busy_s    <= '0;
            gap_cnt   <= '0;
            lvl_cnt   <= '0;
            level     <= '0;
            hold_cnt  <= '0;
            lane      <= '0;
            spawn_req <= '0;
        end else begin
            state     <= state_n;
            busy_m    <= monster_busy;
            busy_s    <= busy_m;
            gap_cnt   <= gap_cnt_n;
            lvl_cnt   <= lvl_cnt_n;
            level     <= level_n;
            hold_cnt  <= hold_cnt_n;
            lane      <= lane_n;
            spawn_req <= spawn_req_n;
        end
    end

    assign q_SP_Idle = (state == SP_IDLE);
    assign q_SP_Gap  = (state == SP_GAP);
    assign q_SP_Pick = (state == SP_PICK);
    assign q_SP_Hold = (state == SP_HOLD);

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Bench for nexys_starship_spawner: random busy traffic scored against an event-level
// model of spawn timing, plus directed reset, game-over, hold-timeout and busy-latency cases.
module tb_nexys_starship_spawner;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam int NCYC = 600;

    logic       timer_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       play_flag = 1'b0;
    logic       gameover_ctrl = 1'b0;
    logic [3:0] monster_busy = 4'b0;
    logic [3:0] spawn_req;
    logic [2:0] level;
    logic       q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int mon_lo = 1000000;
    int mon_hi = 0;
    int play_s = 0;
    logic [3:0] prev_req = 4'b0;

    logic [19:0] exp_q[$];
    logic [15:0] lf[NCYC];
    logic [3:0]  bsch[NCYC];

    nexys_starship_spawner dut (
        .timer_clk     (timer_clk),
        .Reset         (Reset),
        .play_flag     (play_flag),
        .gameover_ctrl (gameover_ctrl),
        .monster_busy  (monster_busy),
        .spawn_req     (spawn_req),
        .level         (level),
        .q_SP_Idle     (q_SP_Idle),
        .q_SP_Gap      (q_SP_Gap),
        .q_SP_Pick     (q_SP_Pick),
        .q_SP_Hold     (q_SP_Hold)
    );

    // clock / cycle counter
    always #5 timer_clk = ~timer_clk;
    always @(posedge timer_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] galois(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    function automatic int level_at(input int n);
        int k;
        if (n <= play_s) return 0;
        k = (n - play_s - 1) / 32;
        return (k > 6) ? 6 : k;
    endfunction

    function automatic int gap_of(input logic [15:0] l, input int lv);
        int b;
        b = 8 - lv;
        if (b < 2) b = 2;
        return b + int'(l[2:0]);
    endfunction

    // Reference: walk gap / pick / hold phases and queue every spawn_req change {cycle, value}
    task automatic build_model(input int s, input int hi);
        int c, h, k, lane;
        logic [3:0] bs;
        logic [15:0] l;
        c = s + gap_of(lf[s], 0) + 1;
        while (c < hi) begin
            bs = bsch[c-2];
            if (bs == 4'hF) begin
                c++;
                continue;
            end
            l = lf[c];
            lane = int'(l[5:4]);
            while (bs[lane]) lane = (lane + 1) % 4;
            if (c + 1 < hi) exp_q.push_back({16'(c + 1), 4'(1 << lane)});
            h = c + 1;
            k = 0;
            while (!bsch[h-2][lane] && k < 3) begin
                h++;
                k++;
            end
            if (h + 1 < hi) exp_q.push_back({16'(h + 1), 4'b0000});
            c = h + gap_of(lf[h], level_at(h)) + 1;
        end
    endtask

    task automatic wait_req(input string name, output bit ok);
        int n;
        n = 0;
        while (spawn_req == 4'b0 && n < 40) begin
            @(negedge timer_clk);
            n++;
        end
        ok = (spawn_req != 4'b0);
        check(name, 32'(ok), 32'd1);
    endtask

    // monitor / scoreboard
    always @(negedge timer_clk) begin
        if (cyc >= mon_lo && cyc < mon_hi) begin
            if (spawn_req !== prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_unexpected: cycle %0d spawn_req %b, no change expected", cyc, spawn_req);
                end else begin
                    check("sb_req_event", 32'({cyc[15:0], spawn_req}), 32'(exp_q.pop_front()));
                end
            end
            check("level_model", 32'(level), 32'(level_at(cyc)));
            check("req_onehot0", 32'($onehot0(spawn_req)), 32'd1);
            check("state_onehot", 32'($onehot({q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold})), 32'd1);
        end
        prev_req <= spawn_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        int r0, r2, i, len, n, lane, r;
        bit ok;
        logic [3:0] v;
        logic [15:0] l;

        for (int j = 0; j < NCYC; j++) bsch[j] = 4'b0;
        repeat (3) @(negedge timer_clk);
        check("rst_req", 32'(spawn_req), 32'd0);
        check("rst_state", 32'({q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold}), 32'b1000);
        check("rst_level", 32'(level), 32'd0);
        check("rst_lfsr", 32'(dut.u_lfsr.value), 32'(SEED));

        // random play run scored by the model
        r0 = cyc;
        Reset = 1'b0;
        for (int j = 0; j < NCYC; j++) lf[j] = SEED;
        for (int j = r0; j < NCYC - 1; j++) lf[j+1] = galois(lf[j]);
        play_s = r0 + 2;
        i = play_s + 1;
        while (i < NCYC) begin
            len = $urandom_range(1, 6);
            v = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            for (int j = 0; j < len && i < NCYC; j++) begin
                bsch[i] = v;
                i++;
            end
        end
        mon_lo = play_s + 1;
        mon_hi = play_s + 260;
        build_model(play_s, mon_hi);
        while (cyc < mon_hi) begin
            monster_busy = bsch[cyc];
            play_flag = (cyc == play_s);
            @(negedge timer_clk);
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("level_saturated", 32'(level), 32'd6);

        // game over while playing at max level
        gameover_ctrl = 1'b1;
        monster_busy = 4'b0;
        @(negedge timer_clk);
        gameover_ctrl = 1'b0;
        check("go_play_state", 32'({q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold}), 32'b1000);
        check("go_play_req", 32'(spawn_req), 32'd0);
        check("go_play_level", 32'(level), 32'd0);

        // restart; unanswered request is abandoned after 4 ticks
        play_flag = 1'b1;
        @(negedge timer_clk);
        play_flag = 1'b0;
        check("restart_gap", 32'(q_SP_Gap), 32'd1);
        wait_req("req_after_restart", ok);
        n = 0;
        while (spawn_req != 4'b0 && n < 10) begin
            @(negedge timer_clk);
            n++;
        end
        check("hold_abandon_len", 32'(n), 32'd4);

        // game over during hold
        wait_req("second_req", ok);
        gameover_ctrl = 1'b1;
        @(negedge timer_clk);
        gameover_ctrl = 1'b0;
        check("go_hold_state", 32'({q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold}), 32'b1000);
        check("go_hold_req", 32'(spawn_req), 32'd0);

        // reset mid-hold takes effect immediately
        play_flag = 1'b1;
        @(negedge timer_clk);
        play_flag = 1'b0;
        wait_req("req_before_reset", ok);
        Reset = 1'b1;
        #1;
        check("rst_hold_req", 32'(spawn_req), 32'd0);
        check("rst_hold_state", 32'({q_SP_Idle, q_SP_Gap, q_SP_Pick, q_SP_Hold}), 32'b1000);
        check("rst_hold_level", 32'(level), 32'd0);
        check("rst_hold_lfsr", 32'(dut.u_lfsr.value), 32'(SEED));

        // first request timing and lane straight out of reset
        @(negedge timer_clk);
        r2 = cyc;
        Reset = 1'b0;
        play_flag = 1'b1;
        @(negedge timer_clk);
        play_flag = 1'b0;
        l = SEED;
        for (int j = 0; j < gap_of(SEED, 0) + 1; j++) l = galois(l);
        lane = int'(l[5:4]);
        wait_req("first_req_seen", ok);
        check("first_req_cycle", 32'(cyc), 32'(r2 + gap_of(SEED, 0) + 2));
        check("first_req_lane", 32'(spawn_req), 32'(1 << lane));

        // lane reports busy right away: request drops after the synchronizer delay
        r = cyc;
        monster_busy = spawn_req;
        n = 0;
        while (spawn_req != 4'b0 && n < 10) begin
            @(negedge timer_clk);
            n++;
        end
        check("busy_exit_cycle", 32'(cyc), 32'(r + 3));
        check("busy_exit_gap", 32'(q_SP_Gap), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
